// File: rtl/bist_misr_ora_if.sv
// Controller <-> response analyser bus: session setup, response stream, and status.
interface bist_misr_ora_if #(
    parameter int N  = 8,
    parameter int CW = 16
) ();
    logic          start;
    logic [N-1:0]  poly;
    logic [N-1:0]  seed;
    logic [CW-1:0] num_patterns;
    logic [N-1:0]  golden;
    logic [N-1:0]  din;
    logic          din_valid;
    logic [N-1:0]  signature;
    logic          busy;
    logic          done;
    logic          pass;

    modport master (
        output start, poly, seed, num_patterns, golden, din, din_valid,
        input  signature, busy, done, pass
    );

    modport slave (
        input  start, poly, seed, num_patterns, golden, din, din_valid,
        output signature, busy, done, pass
    );
endinterface

// File: rtl/bist_misr_ora.sv
// BIST output response analyser: right-shift Galois MISR over a counted number of
// valid response beats, then a single-cycle compare against the golden signature.
module bist_misr_ora #(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input logic              clk,
    input logic              rst,
    bist_misr_ora_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sig;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lat;
    logic          pass_q;
    logic [N-1:0]  fb;
    logic [N-1:0]  misr_nxt;
    logic          last_beat;

    // Stage N-1 always takes s[0]; forcing that bit makes poly[N-1] a don't-care.
    assign fb        = sig[0] ? (bus.poly | {1'b1, {(N-1){1'b0}}}) : '0;
    assign misr_nxt  = {1'b0, sig[N-1:1]} ^ fb ^ bus.din;
    assign last_beat = (cnt == lat - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start)
                            state_nxt = (bus.num_patterns == '0) ? CMP : RUN;
            RUN:        if (bus.din_valid && last_beat) state_nxt = CMP;
            CMP:        state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig    <= '0;
            cnt    <= '0;
            lat    <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    sig    <= bus.seed;
                    cnt    <= '0;
                    lat    <= bus.num_patterns;
                    pass_q <= 1'b0;
                end
                RUN: if (bus.din_valid) begin
                    sig <= misr_nxt;
                    cnt <= cnt + CW'(1);
                end
                CMP:     pass_q <= (sig == bus.golden);
                default: ;
            endcase
        end
    end

    // pass_q is only set on the CMP->DONE edge and cleared on any restart.
    assign bus.signature = sig;
    assign bus.busy      = (state == RUN) || (state == CMP);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_q;
endmodule

// File: tb/tb_bist_misr_ora.sv
// Randomized scoreboard bench for bist_misr_ora (N=4 main instance, N=8 LFSR check).
module tb_bist_misr_ora;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bist_misr_ora_if #(.N(4), .CW(16)) b4 ();
    bist_misr_ora_if #(.N(8), .CW(16)) b8 ();

    bist_misr_ora #(.N(4), .CW(16)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    bist_misr_ora #(.N(8), .CW(16)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] sig;
        logic       pass;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference MISR step written directly from the per-bit rule.
    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] p,
                                            input logic [7:0] d, input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n - 1; i++) r[i] = (s[0] & p[i]) ^ s[i+1] ^ d[i];
        r[n-1] = s[0] ^ d[n-1];
        return r;
    endfunction

    // Monitor: compares each completed session against the scoreboard.
    logic done_d = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_done_exclusive", {31'd0, b4.busy & b4.done}, 32'd0);
            chk("pass_without_done", {31'd0, b4.pass & ~b4.done}, 32'd0);
            if (b4.done && !done_d) begin
                if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("sb_signature", {28'd0, b4.signature}, {28'd0, e.sig});
                    chk("sb_pass", {31'd0, b4.pass}, {31'd0, e.pass});
                end
            end
        end
        done_d <= b4.done;
    end

    task automatic session(input logic [3:0] sd, input logic [3:0] pl, input logic [3:0] gd,
                           input int np, input int gap, input bit gexp, input bit start_in_run);
        logic [3:0] w[$];
        logic [3:0] s, g;
        logic [7:0] r8;
        for (int k = 0; k < np; k++)
            if (dq.size() > 0) w.push_back(dq.pop_front());
            else               w.push_back(4'($urandom));
        s = sd;
        for (int k = 0; k < np; k++) begin
            r8 = misr_ref({4'd0, s}, {4'd0, pl}, {4'd0, w[k]}, 4);
            s  = r8[3:0];
        end
        g = gexp ? s : gd;

        b4.poly = pl; b4.seed = sd; b4.num_patterns = 16'(np); b4.golden = g;
        b4.din_valid = 1'b0; b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        chk("start_clears_done", {31'd0, b4.done}, 32'd0);
        chk("start_clears_pass", {31'd0, b4.pass}, 32'd0);
        chk("start_loads_seed", {28'd0, b4.signature}, {28'd0, sd});
        chk("busy_after_start", {31'd0, b4.busy}, 32'd1);

        s = sd;
        for (int k = 0; k < np; k++) begin
            for (int gi = 0; gi < gap; gi++) begin
                b4.din_valid = 1'b0;
                b4.din       = 4'($urandom);
                if (start_in_run && gi == 0) begin
                    b4.start        = 1'b1;
                    b4.seed         = 4'($urandom);
                    b4.num_patterns = 16'($urandom);
                end
                @(posedge clk); #1;
                b4.start = 1'b0;
                chk("gap_holds_signature", {28'd0, b4.signature}, {28'd0, s});
                chk("busy_in_run", {31'd0, b4.busy}, 32'd1);
            end
            b4.din = w[k]; b4.din_valid = 1'b1;
            @(posedge clk); #1;
            r8 = misr_ref({4'd0, s}, {4'd0, pl}, {4'd0, w[k]}, 4);
            s  = r8[3:0];
            chk("beat_signature", {28'd0, b4.signature}, {28'd0, s});
        end
        b4.din_valid = 1'b0;
        sbq.push_back('{sig: s, pass: (s == g)});
        chk("cmp_cycle_not_done", {31'd0, b4.done}, 32'd0);
        @(posedge clk); #1;
        chk("done_latency", {31'd0, b4.done}, 32'd1);
        chk("busy_low_in_done", {31'd0, b4.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] s8, t8;
        b4.start = 0; b4.poly = 0; b4.seed = 0; b4.num_patterns = 0;
        b4.golden = 0; b4.din = 0; b4.din_valid = 0;
        b8.start = 0; b8.poly = 0; b8.seed = 0; b8.num_patterns = 0;
        b8.golden = 0; b8.din = 0; b8.din_valid = 0;
        #2;
        chk("reset_signature", {28'd0, b4.signature}, 32'd0);
        chk("reset_busy", {31'd0, b4.busy}, 32'd0);
        chk("reset_done", {31'd0, b4.done}, 32'd0);
        chk("reset_pass", {31'd0, b4.pass}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic compression, then mismatch with the signature held in DONE.
        dq = '{4'h1, 4'h2, 4'h3};
        session(4'h0, 4'h3, 4'hC, 3, 0, 1'b0, 1'b0);
        chk("basic_final_sig", {28'd0, b4.signature}, 32'hC);
        dq = '{4'h1, 4'h2, 4'h3};
        session(4'h0, 4'h3, 4'hD, 3, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mismatch_sig_held", {28'd0, b4.signature}, 32'hC);
        chk("mismatch_pass_low", {31'd0, b4.pass}, 32'd0);
        chk("mismatch_done_held", {31'd0, b4.done}, 32'd1);

        // Gapped valids with a stray start pulse mid-run.
        dq = '{4'h1, 4'h2, 4'h3};
        session(4'h0, 4'h3, 4'hC, 3, 2, 1'b0, 1'b1);
        chk("gapped_final_sig", {28'd0, b4.signature}, 32'hC);

        session(4'h5, 4'h3, 4'h5, 0, 0, 1'b0, 1'b0);
        chk("zero_patterns_sig", {28'd0, b4.signature}, 32'h5);

        // Async reset mid-run abandons the session.
        b4.poly = 4'h3; b4.seed = 4'h0; b4.num_patterns = 16'd3; b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0; b4.din_valid = 1'b1; b4.din = 4'h1;
        @(posedge clk); #1;
        b4.din = 4'h2;
        @(posedge clk); #1;
        b4.din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_signature", {28'd0, b4.signature}, 32'd0);
        chk("rst_mid_busy", {31'd0, b4.busy}, 32'd0);
        chk("rst_mid_done", {31'd0, b4.done}, 32'd0);
        chk("rst_mid_pass", {31'd0, b4.pass}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        dq = '{4'h1, 4'h2, 4'h3};
        session(4'h0, 4'h3, 4'hC, 3, 0, 1'b0, 1'b0);
        chk("post_reset_sig", {28'd0, b4.signature}, 32'hC);

        // Randomized back-to-back sessions (each start arrives while in DONE).
        for (int t = 0; t < 24; t++)
            session(4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(8, 0)),
                    int'($urandom_range(2, 0)), 1'($urandom), 1'($urandom));
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 32'd0);

        // With din=0 the MISR is the maximal-length LFSR: period 255.
        b8.poly = 8'hB8; b8.seed = 8'h01; b8.num_patterns = 16'd255; b8.golden = 8'h01;
        b8.din = 8'h00; b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0; b8.din_valid = 1'b1;
        s8 = 8'h01;
        for (int k = 0; k < 255; k++) begin
            t8 = misr_ref(s8, 8'hB8, 8'h00, 8);
            s8 = t8;
            @(posedge clk); #1;
        end
        b8.din_valid = 1'b0;
        chk("lfsr_model_sig", {24'd0, b8.signature}, {24'd0, s8});
        chk("lfsr_period_255", {24'd0, b8.signature}, 32'h01);
        @(posedge clk); #1;
        chk("lfsr_done", {31'd0, b8.done}, 32'd1);
        chk("lfsr_pass", {31'd0, b8.pass}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
